sim_uart_out_arbiter: RTL and testbench

- Shares the single simulation UART output channel among NUM_REQ character sources, e.g. per-core consoles in a multi-core SimTop.
- Round-robin arbitration with line locking: once a source wins, it keeps the grant until it sends '\n' (8'h0a) or times out, so console lines never interleave.
- A small output FIFO decouples sources from the testbench sink. The sink prints out_ch on each cycle where out_valid and out_ready are both high.

---
 rtl/sim_uart_pkg.sv | 34 +++
 rtl/sim_uart_out_arbiter_if.sv | 24 ++
 rtl/sim_uart_fifo.sv | 35 +++
 rtl/sim_uart_out_arbiter.sv | 107 ++++++++++
 tb/tb_sim_uart_out_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sim_uart_pkg.sv
// Shared types and helpers for the simulation UART output arbiter.
package sim_uart_pkg;

  localparam logic [7:0] UART_NEWLINE = 8'h0a;
  localparam int         MAX_REQ      = 8;

  typedef enum logic {IDLE, LOCKED} arb_state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping modulo n (n <= MAX_REQ).
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t   r;
    logic [2:0] j;
    r = '0;
    // Descending scan so the smallest offset from ptr is written last.
    for (int k = MAX_REQ-1; k >= 0; k--) begin
      if (k < n) begin
        j = 3'((int'(ptr) + k) % n);
        if (valid[j]) begin
          r.found = 1'b1;
          r.idx   = j;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sim_uart_out_arbiter_if.sv
// Request/sink bundle of the simulation UART output arbiter.
interface sim_uart_out_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0][7:0] req_ch;
  logic [NUM_REQ-1:0]      req_ready;
  logic                    out_valid;
  logic [7:0]              out_ch;
  logic                    out_ready;
  logic                    lock_valid;
  logic [IDW-1:0]          lock_id;

  modport master (
    output req_valid, req_ch, out_ready,
    input  req_ready, out_valid, out_ch, lock_valid, lock_id
  );

  modport slave (
    input  req_valid, req_ch, out_ready,
    output req_ready, out_valid, out_ch, lock_valid, lock_id
  );
endinterface

// File: rtl/sim_uart_fifo.sv
// Character FIFO with registered storage; head reads as 0 while empty.
module sim_uart_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [7:0] head
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/sim_uart_out_arbiter.sv
// Round-robin, line-locked arbiter sharing the sim UART output among NUM_REQ sources.
module sim_uart_out_arbiter
  import sim_uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int FIFO_DEPTH   = 16,
  parameter int LOCK_TIMEOUT = 256
) (
  input logic                   clock,
  input logic                   reset,
  sim_uart_out_arbiter_if.slave bus
);
  localparam int IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW  = $clog2(LOCK_TIMEOUT + 1);

  arb_state_e         state;
  logic [IDW-1:0]     owner, rr_ptr, grant;
  logic [CW-1:0]      cnt;
  logic [MAX_REQ-1:0] valid8;
  rr_pick_t           pick;
  logic [NUM_REQ-1:0] ready;
  logic               full, empty, push, is_nl;
  logic [7:0]         push_ch, head;

  function automatic logic [IDW-1:0] inc_id(input logic [IDW-1:0] i);
    return (i == IDW'(NUM_REQ-1)) ? '0 : i + IDW'(1);
  endfunction

  always_comb begin
    valid8 = '0;
    valid8[NUM_REQ-1:0] = bus.req_valid;
    pick  = rr_pick(valid8, 3'(rr_ptr), NUM_REQ);
    grant = (state == LOCKED) ? owner : pick.idx[IDW-1:0];
    ready = '0;
    // Gated by reset so nothing is offered while the slice is being cleared.
    if (reset && !full && (state == LOCKED || pick.found)) ready[grant] = 1'b1;
  end

  assign push    = |(bus.req_valid & ready);
  assign push_ch = bus.req_ch[grant];
  assign is_nl   = (push_ch == UART_NEWLINE);

  assign bus.req_ready = ready;
  assign bus.out_valid = !empty;
  assign bus.out_ch    = head;

  sim_uart_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .din   (push_ch),
    .pop   (bus.out_ready),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state          <= IDLE;
      owner          <= '0;
      rr_ptr         <= '0;
      cnt            <= '0;
      bus.lock_valid <= 1'b0;
      bus.lock_id    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (push) begin
            if (is_nl) begin
              rr_ptr <= inc_id(grant);
            end else begin
              state          <= LOCKED;
              owner          <= grant;
              cnt            <= '0;
              bus.lock_valid <= 1'b1;
              bus.lock_id    <= grant;
            end
          end
        end
        LOCKED: begin
          if (push) begin
            cnt <= '0;
            if (is_nl) begin
              state          <= IDLE;
              rr_ptr         <= inc_id(owner);
              owner          <= '0;
              bus.lock_valid <= 1'b0;
              bus.lock_id    <= '0;
            end
          end else if (cnt == CW'(LOCK_TIMEOUT-1)) begin
            // Forced release: owner went quiet or the sink stalled too long.
            state          <= IDLE;
            rr_ptr         <= inc_id(owner);
            owner          <= '0;
            cnt            <= '0;
            bus.lock_valid <= 1'b0;
            bus.lock_id    <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sim_uart_out_arbiter.sv
// Directed bench for sim_uart_out_arbiter (NUM_REQ=4, FIFO_DEPTH=16, LOCK_TIMEOUT=8).
module tb_sim_uart_out_arbiter;
  localparam int NREQ = 4;
  localparam logic [7:0] NL = 8'h0a;

  typedef struct {
    int         cyc;
    int         src;
    logic [7:0] ch;
    logic       lv;
    logic [1:0] lid;
  } acc_t;

  typedef struct {
    int         cyc;
    logic [7:0] ch;
  } pop_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  bit   ok;

  logic [7:0] src_q [NREQ][$];
  acc_t       acc_log[$];
  pop_t       pop_log[$];
  logic       lv_hist [0:4095];

  sim_uart_out_arbiter_if #(.NUM_REQ(NREQ)) bus ();

  sim_uart_out_arbiter #(.NUM_REQ(NREQ), .FIFO_DEPTH(16), .LOCK_TIMEOUT(8)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Source feeder and logger: samples at negedge, advances queues just after posedge.
  initial begin
    logic [NREQ-1:0] acc;
    bus.req_valid = '0;
    bus.req_ch    = '0;
    forever begin
      @(negedge clock);
      acc = bus.req_valid & bus.req_ready;
      for (int i = 0; i < NREQ; i++)
        if (acc[i]) acc_log.push_back('{cyc, i, bus.req_ch[i], bus.lock_valid, bus.lock_id});
      if (bus.out_valid && bus.out_ready) pop_log.push_back('{cyc, bus.out_ch});
      if (cyc < 4096) lv_hist[cyc] = bus.lock_valid;
      @(posedge clock);
      cyc++;
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && src_q[i].size() != 0) void'(src_q[i].pop_front());
        bus.req_valid[i] = (src_q[i].size() != 0);
        bus.req_ch[i]    = (src_q[i].size() != 0) ? src_q[i][0] : 8'h00;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic clear_logs();
    acc_log.delete();
    pop_log.delete();
  endtask

  task automatic drain(input int max, output bit done);
    done = 1'b0;
    for (int k = 0; k < max && !done; k++) begin
      tick();
      @(negedge clock);
      #1;
      if (src_q[0].size() == 0 && src_q[1].size() == 0 && src_q[2].size() == 0 &&
          src_q[3].size() == 0 && !bus.out_valid && !bus.lock_valid) done = 1'b1;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < NREQ; i++) src_q[i].push_back(NL);
    for (int k = 0; k < 5; k++) begin
      tick();
      @(negedge clock);
      checks++;
      if (bus.req_ready !== 4'b0000) begin
        failures++; $display("FAIL reset_ready: got %b expected 0000", bus.req_ready);
      end
      checks++;
      if ({bus.out_valid, bus.lock_valid, bus.lock_id, bus.out_ch} !== 12'h000) begin
        failures++;
        $display("FAIL reset_outs: got ov=%b lv=%b id=%0d ch=%h expected all 0",
                 bus.out_valid, bus.lock_valid, bus.lock_id, bus.out_ch);
      end
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant: got %b expected 0001", bus.req_ready);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== NL) begin
      failures++; $display("FAIL reset_first_out: got ov=%b ch=%h expected 1/0a", bus.out_valid, bus.out_ch);
    end
    drain(50, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL reset_drain: got timeout expected drained"); end
    checks++;
    if (acc_log.size() != 4 || acc_log[0].src != 0) begin
      failures++; $display("FAIL reset_accepts: got n=%0d expected 4 starting at src0", acc_log.size());
    end
  endtask

  task automatic test_round_robin();
    int exp_src[5] = '{0, 1, 2, 3, 0};
    clear_logs();
    tick();
    src_q[0].push_back(NL); src_q[0].push_back(NL);
    for (int i = 1; i < NREQ; i++) src_q[i].push_back(NL);
    drain(50, ok);
    checks++;
    if (!ok || acc_log.size() != 5 || pop_log.size() != 5) begin
      failures++;
      $display("FAIL rr_count: got acc=%0d pop=%0d expected 5/5", acc_log.size(), pop_log.size());
    end else begin
      for (int k = 0; k < 5; k++) begin
        checks++;
        if (acc_log[k].src != exp_src[k]) begin
          failures++; $display("FAIL rr_order[%0d]: got src%0d expected src%0d", k, acc_log[k].src, exp_src[k]);
        end
        checks++;
        if (pop_log[k].cyc != acc_log[k].cyc + 1 || pop_log[k].ch !== NL) begin
          failures++;
          $display("FAIL rr_latency[%0d]: got pop cyc %0d ch %h expected cyc %0d ch 0a",
                   k, pop_log[k].cyc, pop_log[k].ch, acc_log[k].cyc + 1);
        end
      end
    end
  endtask

  task automatic test_back_pressure();
    clear_logs();
    tick();
    bus.out_ready = 1'b0;
    for (int k = 0; k < 20; k++) src_q[2].push_back(8'h61 + 8'(k));
    for (int k = 0; k < 30; k++) tick();
    @(negedge clock);
    #1;
    checks++;
    if (acc_log.size() != 16) begin
      failures++; $display("FAIL bp_accepted: got %0d expected 16", acc_log.size());
    end
    checks++;
    if (bus.req_ready[2] !== 1'b0) begin
      failures++; $display("FAIL bp_ready: got %b expected 0", bus.req_ready[2]);
    end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_ch !== 8'h61 || pop_log.size() != 0) begin
      failures++;
      $display("FAIL bp_head: got ov=%b ch=%h pops=%0d expected 1/61/0", bus.out_valid, bus.out_ch, pop_log.size());
    end
    tick();
    bus.out_ready = 1'b1;
    drain(200, ok);
    checks++;
    if (!ok || pop_log.size() != 20) begin
      failures++; $display("FAIL bp_drain: got %0d pops expected 20", pop_log.size());
    end else begin
      for (int k = 0; k < 20; k++) begin
        checks++;
        if (pop_log[k].ch !== 8'h61 + 8'(k)) begin
          failures++; $display("FAIL bp_order[%0d]: got %h expected %h", k, pop_log[k].ch, 8'h61 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_line_lock();
    logic [7:0] exp_ch[6] = '{8'h41, 8'h42, NL, 8'h78, 8'h79, NL};
    int         exp_src[6] = '{0, 0, 0, 1, 1, 1};
    clear_logs();
    tick();
    src_q[0].push_back(8'h41); src_q[0].push_back(8'h42); src_q[0].push_back(NL);
    src_q[1].push_back(8'h78); src_q[1].push_back(8'h79); src_q[1].push_back(NL);
    drain(100, ok);
    checks++;
    if (!ok || acc_log.size() != 6 || pop_log.size() != 6) begin
      failures++;
      $display("FAIL lock_count: got acc=%0d pop=%0d expected 6/6", acc_log.size(), pop_log.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        checks++;
        if (pop_log[k].ch !== exp_ch[k] || acc_log[k].src != exp_src[k]) begin
          failures++;
          $display("FAIL lock_order[%0d]: got ch %h src%0d expected ch %h src%0d",
                   k, pop_log[k].ch, acc_log[k].src, exp_ch[k], exp_src[k]);
        end
      end
      checks++;
      if (acc_log[1].lv !== 1'b1 || acc_log[1].lid !== 2'd0) begin
        failures++; $display("FAIL lock_id_src0: got lv=%b id=%0d expected 1/0", acc_log[1].lv, acc_log[1].lid);
      end
      checks++;
      if (acc_log[4].lv !== 1'b1 || acc_log[4].lid !== 2'd1) begin
        failures++; $display("FAIL lock_id_src1: got lv=%b id=%0d expected 1/1", acc_log[4].lv, acc_log[4].lid);
      end
      checks++;
      if (acc_log[5].cyc != acc_log[0].cyc + 5) begin
        failures++; $display("FAIL lock_gapless: got span %0d expected 5", acc_log[5].cyc - acc_log[0].cyc);
      end
    end
  endtask

  task automatic test_timeout();
    int a;
    int held;
    clear_logs();
    tick();
    src_q[1].push_back(8'h5a);
    tick();
    src_q[3].push_back(8'h6b);
    drain(100, ok);
    checks++;
    if (!ok || acc_log.size() != 2 || pop_log.size() != 2) begin
      failures++;
      $display("FAIL to_count: got acc=%0d pop=%0d expected 2/2", acc_log.size(), pop_log.size());
    end else begin
      a = acc_log[0].cyc;
      held = 0;
      for (int k = 1; k <= 8; k++) if (lv_hist[a + k] === 1'b1) held++;
      checks++;
      if (held != 8 || lv_hist[a + 9] !== 1'b0) begin
        failures++; $display("FAIL to_hold: got %0d locked then lv=%b expected 8 then 0", held, lv_hist[a + 9]);
      end
      checks++;
      if (acc_log[1].src != 3 || acc_log[1].cyc != a + 9 || acc_log[1].lv !== 1'b0) begin
        failures++;
        $display("FAIL to_next_grant: got src%0d at +%0d expected src3 at +9", acc_log[1].src, acc_log[1].cyc - a);
      end
      checks++;
      if (pop_log[0].ch !== 8'h5a || pop_log[1].ch !== 8'h6b) begin
        failures++; $display("FAIL to_output: got %h %h expected 5a 6b", pop_log[0].ch, pop_log[1].ch);
      end
    end
  endtask

  task automatic test_midline_reset();
    clear_logs();
    tick();
    bus.out_ready = 1'b0;
    src_q[0].push_back(8'h51);
    src_q[1].push_back(8'h6d);
    tick();
    tick();
    @(negedge clock);
    checks++;
    if (bus.lock_valid !== 1'b1 || bus.lock_id !== 2'd0 || bus.out_ch !== 8'h51 || bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_locked: got lv=%b id=%0d ch=%h rdy=%b expected 1/0/51/0001",
               bus.lock_valid, bus.lock_id, bus.out_ch, bus.req_ready);
    end
    tick();
    reset = 1'b0;
    src_q[0].push_back(8'h50);
    @(negedge clock);
    checks++;
    if (bus.req_ready !== 4'b0000) begin
      failures++; $display("FAIL mid_reset_ready: got %b expected 0000", bus.req_ready);
    end
    tick();
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.lock_valid !== 1'b0 || bus.req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL mid_cleared: got ov=%b lv=%b rdy=%b expected 0/0/0001", bus.out_valid, bus.lock_valid, bus.req_ready);
    end
    tick();
    @(negedge clock);
    checks++;
    if (bus.out_ch !== 8'h50 || bus.lock_valid !== 1'b1 || bus.lock_id !== 2'd0) begin
      failures++;
      $display("FAIL mid_regrant: got ch=%h lv=%b id=%0d expected 50/1/0", bus.out_ch, bus.lock_valid, bus.lock_id);
    end
    tick();
    bus.out_ready = 1'b1;
    drain(100, ok);
    checks++;
    if (!ok || pop_log.size() != 2 || pop_log[0].ch !== 8'h50 || pop_log[1].ch !== 8'h6d) begin
      failures++; $display("FAIL mid_output: got %0d pops expected 50 6d", pop_log.size());
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    test_reset();
    test_round_robin();
    test_back_pressure();
    test_line_lock();
    test_timeout();
    test_midline_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
